// File: rtl/run_detector_pkg.sv
// Shared types for the run detector: FSM state encoding and output-mode decoding.
// Optional hit counter is enabled by defining RUN_DETECTOR_HITCNT_EN.
package run_detector_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2,
        HOLD = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'd0,
        MODE_PULSE = 2'd1,
        MODE_GROUP = 2'd2
    } mode_e;

    // Any MODE value outside the defined set falls back to level mode.
    function automatic mode_e decode_mode(input int unsigned mode);
        case (mode)
            1:       return MODE_PULSE;
            2:       return MODE_GROUP;
            default: return MODE_LEVEL;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clr together with en&inc restarts the count at 1.
module sat_counter #(
    parameter int unsigned       WIDTH = 8,
    parameter logic [WIDTH-1:0]  MAX   = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = (en && inc) ? WIDTH'(1) : '0;
        end else if (en && inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignment; reset is asynchronous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/run_detector.sv
// Detects runs of RUN_LEN consecutive ones on wi; zo behaviour selected by MODE.
// Define RUN_DETECTOR_HITCNT_EN to add the saturating hit_cnt output.
module run_detector
    import run_detector_pkg::*;
#(
    parameter int unsigned RUN_LEN = 3,
    parameter int unsigned MODE    = 0,
    parameter int unsigned HIT_W   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clr,
    input  logic                           en,
    input  logic                           wi,
    output logic                           zo,
    output logic [$clog2(RUN_LEN+1)-1:0]   run_cnt
`ifdef RUN_DETECTOR_HITCNT_EN
    ,
    output logic [HIT_W-1:0]               hit_cnt
`endif
);

    localparam int unsigned      RUN_W    = $clog2(RUN_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RUN_LEN);
    localparam mode_e            MODE_EFF = decode_mode(MODE);

    state_e           state_q, state_d;
    logic             zo_q, zo_d;
    logic             run_clr, run_inc;
    logic [RUN_W-1:0] run_cnt_q;

    always_comb begin
        state_d = state_q;
        run_clr = 1'b0;
        run_inc = 1'b0;
        if (clr) begin
            state_d = IDLE;
            run_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en && wi) begin
                        state_d = RUN;
                        run_inc = 1'b1;
                    end
                end
                RUN: begin
                    if (en && wi) begin
                        run_inc = 1'b1;
                        if (run_cnt_q == RUN_MAX - RUN_W'(1)) begin
                            state_d = HIT;
                        end
                    end else if (en) begin
                        state_d = IDLE;
                        run_clr = 1'b1;
                    end
                end
                HIT: begin
                    if (en && wi) begin
                        if (MODE_EFF == MODE_GROUP) begin
                            // Start the next non-overlapping group at a count of one.
                            state_d = RUN;
                            run_clr = 1'b1;
                            run_inc = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end else if (en) begin
                        state_d = IDLE;
                        run_clr = 1'b1;
                    end
                end
                HOLD: begin
                    if (en && !wi) begin
                        state_d = IDLE;
                        run_clr = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_clr = 1'b1;
                end
            endcase
        end
    end

    assign zo_d = (state_d == HIT) ||
                  ((state_d == HOLD) && (MODE_EFF == MODE_LEVEL));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            zo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            zo_q    <= zo_d;
        end
    end

    sat_counter #(
        .WIDTH (RUN_W),
        .MAX   (RUN_MAX)
    ) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (run_clr),
        .en    (en),
        .inc   (run_inc),
        .cnt   (run_cnt_q)
    );

`ifdef RUN_DETECTOR_HITCNT_EN
    logic hit_inc;

    // HIT is only ever entered from RUN, so this marks each new match event.
    assign hit_inc = (state_q == RUN) && (state_d == HIT);

    sat_counter #(
        .WIDTH (HIT_W),
        .MAX   ({HIT_W{1'b1}})
    ) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .inc   (hit_inc),
        .cnt   (hit_cnt)
    );
`endif

    assign zo      = zo_q;
    assign run_cnt = run_cnt_q;

endmodule

// File: tb/tb_run_detector.sv
// Randomised scoreboard bench: four detectors (MODE 0,1,2 and illegal 3) share one stimulus stream
// and are compared every cycle against a consecutive-ones reference model.
module tb_run_detector;

    localparam int RUN_LEN = 3;
    localparam int N_DUT   = 4;

    typedef struct packed {
        logic [N_DUT-1:0]       zo;
        logic [N_DUT-1:0][1:0]  run;
        logic [N_DUT-1:0][7:0]  hit;
    } exp_t;

    logic clk;
    logic reset;
    logic clr;
    logic en;
    logic wi;
    logic       zo      [N_DUT];
    logic [1:0] run_cnt [N_DUT];
`ifdef RUN_DETECTOR_HITCNT_EN
    logic [7:0] hit_cnt [N_DUT];
`endif

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        run_detector #(
            .RUN_LEN (RUN_LEN),
            .MODE    (g),
            .HIT_W   (8)
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .clr     (clr),
            .en      (en),
            .wi      (wi),
            .zo      (zo[g]),
            .run_cnt (run_cnt[g])
`ifdef RUN_DETECTOR_HITCNT_EN
            ,
            .hit_cnt (hit_cnt[g])
`endif
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: length of the current unbroken streak of sampled ones.
    int   ones;
    int   hits [N_DUT];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, wanted %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_mode(input int i);
        return (i == 3) ? 0 : i;
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        int   m;
        e = '0;
        for (int i = 0; i < N_DUT; i++) begin
            m = eff_mode(i);
            if (m == 2) begin
                e.run[i] = 2'((ones == 0) ? 0 : ((ones - 1) % RUN_LEN) + 1);
                e.zo[i]  = (ones > 0) && (ones % RUN_LEN == 0);
            end else begin
                e.run[i] = 2'((ones < RUN_LEN) ? ones : RUN_LEN);
                e.zo[i]  = (m == 0) ? (ones >= RUN_LEN) : (ones == RUN_LEN);
            end
            e.hit[i] = 8'(hits[i]);
        end
        return e;
    endfunction

    task automatic model_step(input bit e, input bit w, input bit c);
        bit event_hit;
        if (c) begin
            ones = 0;
            for (int i = 0; i < N_DUT; i++) hits[i] = 0;
        end else if (e) begin
            if (w) begin
                ones++;
                for (int i = 0; i < N_DUT; i++) begin
                    event_hit = (eff_mode(i) == 2) ? (ones % RUN_LEN == 0) : (ones == RUN_LEN);
                    if (event_hit && hits[i] < 255) hits[i]++;
                end
            end else begin
                ones = 0;
            end
        end
    endtask

    task automatic compare_all(input exp_t e, input string tag);
        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("%s_zo_m%0d", tag, i), int'(zo[i]), int'(e.zo[i]));
            check($sformatf("%s_run_m%0d", tag, i), int'(run_cnt[i]), int'(e.run[i]));
`ifdef RUN_DETECTOR_HITCNT_EN
            check($sformatf("%s_hit_m%0d", tag, i), int'(hit_cnt[i]), int'(e.hit[i]));
`endif
        end
    endtask

    // Monitor: one expected entry per clock edge, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            compare_all(mon_e, "cyc");
        end
    end

    task automatic step(input bit e, input bit w, input bit c);
        @(negedge clk);
        en  = e;
        wi  = w;
        clr = c;
        model_step(e, w, c);
        @(posedge clk);
        exp_q.push_back(model_exp());
    endtask

    task automatic run_ones(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear without a clock.
    task automatic reset_pulse();
        #2 reset = 1'b1;
        #1;
        ones = 0;
        for (int i = 0; i < N_DUT; i++) hits[i] = 0;
        compare_all(model_exp(), "rst");
        #1 reset = 1'b0;
        void'(exp_q.pop_back());
        exp_q.push_back(model_exp());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    bit r_en, r_wi, r_clr;

    initial begin
        reset = 1'b1;
        clr   = 1'b0;
        en    = 1'b0;
        wi    = 1'b0;
        ones  = 0;
        for (int i = 0; i < N_DUT; i++) hits[i] = 0;
        exp_q.push_back(model_exp());
        @(negedge clk);
        #1 reset = 1'b0;

        // Level/pulse/group behaviour on a short burst.
        step(1, 0, 0);
        run_ones(4);
        step(1, 0, 0);

        // Long runs: single pulse in MODE 1, repeated groups in MODE 2.
        step(1, 0, 1);
        run_ones(8);
        step(1, 0, 0);
        step(1, 0, 1);
        run_ones(9);
        step(1, 0, 0);

        // Freeze with en low mid-run.
        step(1, 0, 1);
        run_ones(2);
        for (int k = 0; k < 4; k++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        run_ones(2);
        step(1, 0, 0);

        // Reset mid-run discards the partial run.
        step(1, 0, 1);
        run_ones(2);
        reset_pulse();
        run_ones(2);
        step(1, 0, 0);

        // clr wins over en&wi while holding.
        step(1, 0, 1);
        run_ones(5);
        step(1, 1, 1);
        step(1, 0, 0);

        // Hit counter saturation (MODE 2 reaches 256 events).
        step(1, 0, 1);
        run_ones(770);
        step(1, 0, 0);

        for (int k = 0; k < 400; k++) begin
            r_en  = ($urandom_range(0, 99) < 85);
            r_wi  = ($urandom_range(0, 99) < 75);
            r_clr = ($urandom_range(0, 99) < 2);
            step(r_en, r_wi, r_clr);
            if ($urandom_range(0, 99) == 0) reset_pulse();
        end

        repeat (3) @(negedge clk);
        #1;
        check("drain_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/run_detector.md
RUN_DETECTOR -- requirements
Module: run_detector

Interface
REQ-001 Parameter RUN_LEN, default 3, number of consecutive wi=1 samples that constitutes a match; legal range 2..255.
REQ-002 Parameter MODE, default 0, output mode: 0 = level, 1 = single pulse per run, 2 = non-overlapping pulse every RUN_LEN ones.
REQ-003 Parameter HIT_W, default 8, width of the match event counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 clr  input  1  synchronous clear of state, run count and hit count.
REQ-007 en  input  1  sample enable; wi is ignored and all state holds when low.
REQ-008 wi  input  1  serial data bit under test.
REQ-009 zo  output  1  match indication, per MODE.
REQ-010 run_cnt  output  $clog2(RUN_LEN+1)  current run length, saturating at RUN_LEN.
REQ-011 hit_cnt  output  HIT_W  number of zo assertion events, present only per REQ-027.

Function
REQ-012 FSM states SHALL be exactly IDLE, RUN, HIT, HOLD.
REQ-013 IDLE: en&wi -> RUN with run_cnt=1; else stay.
REQ-014 RUN: en&wi -> run_cnt+1, and -> HIT when run_cnt+1 == RUN_LEN; en&!wi -> IDLE with run_cnt=0.
REQ-015 HIT, MODE 0 or 1: en&wi -> HOLD; en&!wi -> IDLE, run_cnt=0.
REQ-016 HIT, MODE 2: en&wi -> RUN with run_cnt=1 (new group); en&!wi -> IDLE, run_cnt=0.
REQ-017 HOLD: en&wi -> stay; en&!wi -> IDLE, run_cnt=0.
REQ-018 zo SHALL be a Moore output: 1 in HIT; also 1 in HOLD when MODE=0; 0 in every other state.
REQ-019 zo therefore rises exactly one cycle after the edge that samples the RUN_LEN-th consecutive 1.
REQ-020 run_cnt SHALL saturate at RUN_LEN in HIT/HOLD (MODE 0/1) and never wrap.
REQ-021 en low SHALL freeze state, run_cnt and hit_cnt; zo continues to reflect the frozen state.
REQ-022 clr SHALL take priority over en and wi: next state IDLE, run_cnt=0, hit_cnt=0.
REQ-023 Illegal/unreachable state encodings SHALL return to IDLE on the next clock edge.
REQ-024 Illegal MODE values SHALL behave as MODE 0.

Reset
REQ-025 reset high SHALL immediately force state IDLE, zo=0, run_cnt=0, hit_cnt=0, independent of clk.
REQ-026 Reset asserted mid-run SHALL discard the partial run; counting restarts from the first wi=1 after release.

Configuration
REQ-027 With RUN_DETECTOR_HITCNT_EN defined: hit_cnt port exists, increments by 1 on each entry into HIT, saturates at 2^HIT_W-1.
REQ-028 Without RUN_DETECTOR_HITCNT_EN: hit_cnt port and its logic are absent; all other behaviour unchanged.

Structure
REQ-029 State typedef (IDLE/RUN/HIT/HOLD encoding) and MODE constants SHALL live in shared package run_detector_pkg.
REQ-030 Saturating counter SHALL be a sub-module sat_counter (width parameter, inc, clr, en), instantiated for run_cnt and hit_cnt.

Verification (RUN_LEN=3 unless stated)
REQ-031 MODE 0, en=1, wi=0,1,1,1,1,0 -> zo=0,0,0,0,1,1,0 (one-cycle lag); run_cnt peaks at 3.
REQ-032 MODE 1, wi held 1 for 8 cycles -> zo exactly one 1-cycle pulse; hit_cnt=1.
REQ-033 MODE 2, wi held 1 for 9 cycles -> three zo pulses, 3 cycles apart; hit_cnt=3.
REQ-034 MODE 0, wi=1,1, en=0 for 4 cycles, then wi=1 with en=1 -> zo rises 1 cycle later; run_cnt holds 2 during freeze.
REQ-035 wi=1,1 then reset pulse between edges -> zo=0, run_cnt=0 immediately; two further ones give no zo.
REQ-036 clr and en&wi asserted in the same cycle while in HOLD -> next cycle IDLE, zo=0, run_cnt=0, hit_cnt=0.
